// File: rtl/io_handshake_responder_pkg.sv
// Shared encodings for the I/O handshake responder: FSM states, request modes and mode decode.
package io_handshake_responder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StPressed = 2'd2,
        StAck     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ModeNone  = 2'd0,
        ModeOut   = 2'd1,
        ModeIn    = 2'd2,
        ModePause = 2'd3
    } mode_e;

    function automatic mode_e decode_mode(input logic is_input, input logic is_output);
        mode_e m;
        case ({is_input, is_output})
            2'b01:   m = ModeOut;
            2'b10:   m = ModeIn;
            2'b11:   m = ModePause;
            default: m = ModeNone;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/io_handshake_responder_button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw pushbutton.
module io_handshake_responder_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q, level_q;
    logic [CntW-1:0] cnt_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CntMax) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral end of the core's OUTPUT/INPUT/PAUSE handshake.
// Define IO_AUTO_ACK_EN to replace the button handshake with a fixed-delay auto-acknowledge.
module io_handshake_responder
    import io_handshake_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SWITCH_WIDTH    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned AUTO_ACK_DELAY  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic [DATA_WIDTH-1:0]   output_value,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic                    confirm_button_raw,
    input  logic                    continue_button_raw,
    output logic                    confirmation,
    output logic                    continue_button,
    output logic [DATA_WIDTH-1:0]   input_value,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    waiting
);
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (AUTO_ACK_DELAY < 1) begin : g_bad_auto_ack
        $error("AUTO_ACK_DELAY must be at least 1");
    end

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d, req_mode;
    logic [DATA_WIDTH-1:0]   display_q, display_d, input_q, input_d;
    logic [SWITCH_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
    logic                    confirmation_q, continue_q, abort;

    assign req_mode = decode_mode(is_input, is_output);
    // mode_q is never ModeNone while armed, so dropped flags also count as a mismatch.
    assign abort    = (req_mode != mode_q);

`ifdef IO_AUTO_ACK_EN
    localparam int unsigned AckW = (AUTO_ACK_DELAY > 1) ? $clog2(AUTO_ACK_DELAY) : 1;
    localparam logic [AckW-1:0] AckMax = AckW'(AUTO_ACK_DELAY - 1);
    logic [AckW-1:0] ack_cnt_q, ack_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) ack_cnt_q <= '0;
        else       ack_cnt_q <= ack_cnt_d;
    end
`else
    logic conf_level, cont_level, conf_prev_q, cont_prev_q, sel_level, sel_prev;

    io_handshake_responder_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm_db (
        .clock(clock),
        .reset(reset),
        .raw  (confirm_button_raw),
        .level(conf_level)
    );

    io_handshake_responder_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_continue_db (
        .clock(clock),
        .reset(reset),
        .raw  (continue_button_raw),
        .level(cont_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            conf_prev_q <= 1'b0;
            cont_prev_q <= 1'b0;
        end else begin
            conf_prev_q <= conf_level;
            cont_prev_q <= cont_level;
        end
    end

    assign sel_level = (mode_q == ModePause) ? cont_level : conf_level;
    assign sel_prev  = (mode_q == ModePause) ? cont_prev_q : conf_prev_q;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        display_d = display_q;
        input_d   = input_q;
`ifdef IO_AUTO_ACK_EN
        ack_cnt_d = ack_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_mode != ModeNone) begin
                    state_d = StArmed;
                    mode_d  = req_mode;
                    if (req_mode == ModeOut) display_d = output_value;
`ifdef IO_AUTO_ACK_EN
                    ack_cnt_d = '0;
`endif
                end
            end
            StArmed: begin
                if (abort) begin
                    state_d = StIdle;
`ifdef IO_AUTO_ACK_EN
                end else if (ack_cnt_q == AckMax) begin
                    state_d = StAck;
                    if (mode_q == ModeIn) input_d = DATA_WIDTH'(sw_sync2_q);
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
`else
                end else if (sel_level && !sel_prev) begin
                    state_d = StPressed;
`endif
                end
            end
            StPressed: begin
                if (abort) begin
                    state_d = StIdle;
`ifndef IO_AUTO_ACK_EN
                end else if (!sel_level) begin
                    state_d = StAck;
                    if (mode_q == ModeIn) input_d = DATA_WIDTH'(sw_sync2_q);
`endif
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            mode_q         <= ModeNone;
            display_q      <= '0;
            input_q        <= '0;
            sw_sync1_q     <= '0;
            sw_sync2_q     <= '0;
            confirmation_q <= 1'b0;
            continue_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            display_q      <= display_d;
            input_q        <= input_d;
            sw_sync1_q     <= switches;
            sw_sync2_q     <= sw_sync1_q;
            confirmation_q <= (state_d == StAck) && (mode_q != ModePause);
            continue_q     <= (state_d == StAck) && (mode_q == ModePause);
        end
    end

    assign confirmation    = confirmation_q;
    assign continue_button = continue_q;
    assign input_value     = input_q;
    assign display_value   = display_q;
    assign waiting         = (state_q == StArmed) || (state_q == StPressed);

endmodule
